// File: rtl/cpu_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encodings, requester port IDs
// and the read-latency counter sizing.
package cpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int RAM_LAT_MAX = 7;
    localparam int LAT_W       = $clog2(RAM_LAT_MAX + 1);

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selector for the RAM arbiter.
// RAM_ARB_RR_EN selects round-robin on simultaneous requests; otherwise D has fixed priority.
module ram_arb_pick
    import cpu_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef RAM_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic grant
);

    always_comb begin
        grant = PORT_IF;
        if (if_req && d_req) begin
`ifdef RAM_ARB_RR_EN
            // The port that was not served last gets this turn.
            grant = ~last_grant;
`else
            grant = PORT_D;
`endif
        end else if (d_req) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between the fetch (IF) and data (D) requesters.
// Optional build macro RAM_ARB_RR_EN enables round-robin arbitration.
module ram_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    arb_state_t        state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              grant;
    logic              tx_we;
    logic              pick_grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
`ifdef RAM_ARB_RR_EN
    logic              last_grant;
`endif

    ram_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
`ifdef RAM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant      (pick_grant)
    );

    assign sel_we   = (pick_grant == PORT_D) && d_we;
    assign sel_addr = (pick_grant == PORT_D) ? d_addr : if_addr;

    // The RAM strobes are loaded on the grant edge so the ACCESS cycle drives them from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            lat_cnt   <= '0;
            grant     <= PORT_IF;
            tx_we     <= 1'b0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_grant <= PORT_IF;
`endif
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (if_req || d_req) begin
                        grant     <= pick_grant;
                        tx_we     <= sel_we;
                        ram_cs    <= 1'b1;
                        ram_we    <= sel_we;
                        ram_oe    <= ~sel_we;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_we ? d_wdata : '0;
                        busy      <= 1'b1;
                        state     <= ARB_ACCESS;
`ifdef RAM_ARB_RR_EN
                        last_grant <= pick_grant;
`endif
                    end
                end
                ARB_ACCESS: begin
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_oe    <= 1'b0;
                    ram_addr  <= '0;
                    ram_wdata <= '0;
                    if (tx_we) begin
                        d_ack <= 1'b1;
                        state <= ARB_DONE;
                    end else begin
                        lat_cnt <= LAT_W'(RAM_LAT - 1);
                        state   <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (lat_cnt == '0) begin
                        if (grant == PORT_D) begin
                            d_rdata <= ram_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= ram_rdata;
                            if_ack   <= 1'b1;
                        end
                        state <= ARB_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ARB_DONE: begin
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level timeline model plus directed pins.
// Follows RAM_ARB_RR_EN in the same way as the design.
module tb_ram_arbiter;
    import cpu_pkg::*;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        ram_cs, ram_we, ram_oe;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    bit          fixed_on = 1'b0;
    logic [31:0] fixed_val = '0;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // RAM read data is a known function of the cycle number, so the model can predict captures.
    function automatic logic [31:0] rfun(input int k);
        if (fixed_on) return fixed_val;
        return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    initial begin
        ram_rdata = rfun(0);
        forever begin
            @(posedge clk);
            #1 ram_rdata = rfun(cyc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        else
            passed++;
    endtask

    // Model: one transaction in flight, described by its start cycle and the latency rules.
    bit          cur_valid = 1'b0;
    logic        cur_port, cur_we;
    logic [31:0] cur_addr, cur_wdata, cur_val;
    int          cur_start, cur_ack;
    int          free_at = 0;
    logic        m_last = PORT_IF;
    logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            cur_valid = 1'b0;
            free_at   = cyc + 1;
            m_last    = PORT_IF;
        end else if (cyc >= free_at && (if_req || d_req)) begin
            if (if_req && d_req) begin
`ifdef RAM_ARB_RR_EN
                cur_port = ~m_last;
`else
                cur_port = PORT_D;
`endif
            end else begin
                cur_port = d_req ? PORT_D : PORT_IF;
            end
            cur_we    = (cur_port == PORT_D) && d_we;
            cur_addr  = (cur_port == PORT_D) ? d_addr : if_addr;
            cur_wdata = d_wdata;
            cur_start = cyc;
            cur_ack   = cyc + 2 + (cur_we ? 0 : L);
            cur_val   = rfun(cyc + 1 + L);
            free_at   = cur_ack + 1;
            m_last    = cur_port;
            cur_valid = 1'b1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
            checkOutput("rst_ram_cs", ram_cs, 0);
            checkOutput("rst_ram_we", ram_we, 0);
            checkOutput("rst_ram_oe", ram_oe, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_if_ack", if_ack, 0);
            checkOutput("rst_d_ack", d_ack, 0);
            checkOutput("rst_if_rdata", if_rdata, 0);
            checkOutput("rst_d_rdata", d_rdata, 0);
            checkOutput("rst_ram_addr", ram_addr, 0);
            checkOutput("rst_ram_wdata", ram_wdata, 0);
        end else begin
            bit acc, ackc, bsy;
            acc  = cur_valid && (cyc == cur_start + 1);
            ackc = cur_valid && (cyc == cur_ack);
            bsy  = cur_valid && (cyc >= cur_start + 1) && (cyc <= cur_ack);
            if (ackc && !cur_we) begin
                if (cur_port == PORT_D) exp_d_rdata = cur_val;
                else exp_if_rdata = cur_val;
            end
            checkOutput("ram_cs", ram_cs, acc);
            checkOutput("ram_we", ram_we, acc && cur_we);
            checkOutput("ram_oe", ram_oe, acc && !cur_we);
            checkOutput("busy", busy, bsy);
            checkOutput("if_ack", if_ack, ackc && cur_port == PORT_IF);
            checkOutput("d_ack", d_ack, ackc && cur_port == PORT_D);
            checkOutput("if_rdata", if_rdata, exp_if_rdata);
            checkOutput("d_rdata", d_rdata, exp_d_rdata);
            if (acc) checkOutput("ram_addr", ram_addr, cur_addr);
            if (acc && cur_we) checkOutput("ram_wdata", ram_wdata, cur_wdata);
        end
    end

    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output int c);
        @(posedge clk);
        #1;
        if (port == PORT_D) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        c = cyc;
    endtask

    task automatic wait_ack(input logic port, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((port == PORT_D) ? d_ack : if_ack) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput("ack_timeout", 0, 1);
    endtask

    task automatic drop_req(input logic port);
        @(posedge clk);
        #1;
        if (port == PORT_D) d_req = 1'b0; else if_req = 1'b0;
    endtask

    task automatic run_pair(output logic first);
        bit got_if = 0, got_d = 0, got_any = 0;
        first = PORT_IF;
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = $urandom();
        d_req = 1'b1; d_we = 1'b0; d_addr = $urandom();
        for (int i = 0; i < 40 && !(got_if && got_d); i++) begin
            @(negedge clk);
            if (if_ack) begin if (!got_any) first = PORT_IF; got_any = 1; got_if = 1; end
            if (d_ack) begin if (!got_any) first = PORT_D; got_any = 1; got_d = 1; end
            @(posedge clk);
            #1;
            if (got_if) if_req = 1'b0;
            if (got_d) d_req = 1'b0;
        end
        if (!(got_if && got_d)) checkOutput("pair_timeout", 0, 1);
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin
        int c, a, a2, s2, bcnt;
        logic first;
        logic a_if, a_d;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state_busy", busy, 0);
        rst_n = 1'b1;

        // IF read, fixed RAM data
        fixed_on = 1'b1; fixed_val = 32'hDEADBEEF;
        applyStimulus(PORT_IF, 1'b0, 32'h10, 32'h0, c);
        wait_ack(PORT_IF, 20, a);
        checkOutput("t1_ack_latency", a - c, 5);
        checkOutput("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        checkOutput("t1_d_ack", d_ack, 0);
        drop_req(PORT_IF);
        fixed_on = 1'b0;

        // Simultaneous requests after an IF grant: D wins in both builds
        run_pair(first);
        checkOutput("pairA_first", first, PORT_D);

        // D write
        applyStimulus(PORT_D, 1'b1, 32'h20, 32'h12345678, c);
        @(negedge clk);
        checkOutput("t2_cs_idle", ram_cs, 0);
        @(negedge clk);
        checkOutput("t2_cs", ram_cs, 1);
        checkOutput("t2_we", ram_we, 1);
        checkOutput("t2_oe", ram_oe, 0);
        checkOutput("t2_addr", ram_addr, 32'h20);
        checkOutput("t2_wdata", ram_wdata, 32'h12345678);
        @(negedge clk);
        checkOutput("t2_d_ack", d_ack, 1);
        drop_req(PORT_D);

        // Simultaneous requests after a D grant: the builds differ here
        for (int p = 0; p < 4; p++) begin
            run_pair(first);
`ifdef RAM_ARB_RR_EN
            checkOutput("pairB_first", first, PORT_IF);
`else
            checkOutput("pairB_first", first, PORT_D);
`endif
        end

        // D read with latency 3
        fixed_on = 1'b1; fixed_val = 32'hCAFEF00D;
        applyStimulus(PORT_D, 1'b0, 32'h4, 32'h0, c);
        a = -1; bcnt = 0;
        for (int i = 0; i < 20 && a < 0; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (d_ack) a = cyc;
        end
        checkOutput("t3_ack_latency", a - c, 5);
        checkOutput("t3_busy_cycles", bcnt, 5);
        checkOutput("t3_d_rdata", d_rdata, 32'hCAFEF00D);
        drop_req(PORT_D);
        fixed_on = 1'b0;

        // Reset in WAIT
        applyStimulus(PORT_D, 1'b0, 32'h44, 32'h0, c);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        checkOutput("t6_cs", ram_cs, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_d_ack", d_ack, 0);
        checkOutput("t6_d_rdata", d_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(PORT_IF, 1'b0, 32'h80, 32'h0, c);
        wait_ack(PORT_IF, 20, a);
        checkOutput("t6_after_reset_latency", a - c, 5);
        drop_req(PORT_IF);

        // Address change after grant, then back-to-back with req held
        applyStimulus(PORT_IF, 1'b0, 32'h100, 32'h0, c);
        @(posedge clk);
        #1 if_addr = 32'h200;
        @(negedge clk);
        checkOutput("t7_ram_addr", ram_addr, 32'h100);
        wait_ack(PORT_IF, 20, a);
        s2 = -1;
        for (int i = 0; i < 10 && s2 < 0; i++) begin
            @(negedge clk);
            if (ram_cs) s2 = cyc;
        end
        checkOutput("t7_idle_gap", s2 - a, 2);
        checkOutput("t7_second_addr", ram_addr, 32'h200);
        wait_ack(PORT_IF, 20, a2);
        drop_req(PORT_IF);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            a_if = if_ack;
            a_d  = d_ack;
            @(posedge clk);
            #1;
            if (if_req) begin
                if (a_if) if_req = 1'b0;
                else if ($urandom_range(0, 7) == 0) if_addr = $urandom();
            end else if ($urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = $urandom();
            end
            if (d_req) begin
                if (a_d) d_req = 1'b0;
                else if ($urandom_range(0, 7) == 0) begin
                    d_addr = $urandom(); d_wdata = $urandom(); d_we = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 3) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom(); d_wdata = $urandom();
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port instruction/data RAM between two requesters: the fetch port (IF, driven by the control FSM's instruction-read step) and the data port (D, used by load/store states). It sits between the control FSM and the RAM and owns ram_cs/ram_we/ram_oe and the RAM address and data buses. Requesters use a req/ack handshake, so the control FSM stalls on ack instead of assuming fixed RAM timing.

Parameters:
ADDR_W, 32, RAM address width
DATA_W, 32, RAM data width
RAM_LAT, 1, RAM read latency in cycles (ram_rdata valid RAM_LAT cycles after the ram_cs/ram_oe cycle); legal range 1..7

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; hold until if_ack
if_addr  in  ADDR_W  fetch address; stable while if_req=1
if_ack  out  1  one-cycle pulse; if_rdata valid in this cycle
if_rdata  out  DATA_W  fetched word; holds last captured value
d_req  in  1  data request; hold until d_ack
d_we  in  1  1=write, 0=read; stable while d_req=1
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle completion pulse
d_rdata  out  DATA_W  load data; holds last captured value
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  RAM output enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
busy  out  1  1 whenever state != IDLE

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (rst_n). All outputs and all state are registered.
- Reset values: every output is 0, state=IDLE, lat_cnt=0, grant=IF, last_grant=IF.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any req=1, latch the grant, address, we and wdata at the clock edge, then go to ACCESS. If no req, stay in IDLE.
- Arbitration when both requests are high in IDLE: D wins (fixed priority). D is never starved.
- ACCESS (exactly 1 cycle): ram_cs=1, ram_addr=latched address.
  - Read: ram_oe=1, then go to WAIT with lat_cnt=RAM_LAT-1.
  - Write: ram_we=1, ram_wdata=latched data, then go to DONE.
- WAIT: ram_cs/oe/we=0. Decrement lat_cnt. When lat_cnt=0, capture ram_rdata into the granted port's rdata register and go to DONE.
- DONE (1 cycle): assert the granted port's ack, then go to IDLE.
- Latency, with req first seen in IDLE at cycle c:
  - Read: ack at cycle c+2+RAM_LAT (c+3 when RAM_LAT=1).
  - Write: ack at cycle c+2.
- Handshake: a requester deasserts req on the edge after it sees ack. A req still high in the IDLE cycle after DONE is treated as a new transaction. Input changes while req=1 are ignored, because the request is latched.
- A req that drops before ack does not abort the transaction already in flight; it completes and acks anyway.
- ram_cs is high for exactly one cycle per transaction. ram_we and ram_oe are never both 1.
- Asynchronous reset mid-transaction: the RAM is released immediately and no ack is issued. Requesters must reissue.
- The non-granted port's ack stays 0 and its rdata is unchanged.
- The IF port has no write capability.

Optional Feature:
RAM_ARB_RR_EN
- Defined: round-robin arbitration on simultaneous requests. The port not granted last wins. last_grant updates at each grant.
- Undefined: fixed D-over-IF priority. last_grant is not implemented.
- Single-requester behaviour is identical in both builds.

Decomposition:
- Shared package cpu_pkg:
  - state encodings ARB_IDLE/ARB_ACCESS/ARB_WAIT/ARB_DONE
  - port IDs PORT_IF=1'b0, PORT_D=1'b1
  - RAM_LAT maximum constant
- One sub-module: ram_arb_pick, a combinational grant selector. Inputs: if_req, d_req, last_grant. Output: grant. It contains the RAM_ARB_RR_EN selection.
- The FSM, latch registers and RAM drive stay in ram_arbiter.

Test Plan:
- IF read only, if_addr=0x10, ram_rdata=0xDEADBEEF, RAM_LAT=1 -> ram_cs/oe high at c+1 only; if_ack at c+3; if_rdata=0xDEADBEEF; d_ack stays 0.
- D write, d_addr=0x20, d_wdata=0x12345678 -> c+1: ram_cs=1, ram_we=1, ram_oe=0, addr 0x20, wdata 0x12345678; d_ack at c+2.
- if_req and d_req rise in the same cycle.
  - Fixed priority: D is served first, then IF.
  - With RAM_ARB_RR_EN: served alternately over 4 repeated pairs, and the second pair starts with IF.
- RAM_LAT=3 read, d_addr=0x4 -> d_ack at c+5; busy high c+1..c+5; ram_rdata captured at c+4.
- rst_n pulsed low during WAIT -> all outputs 0 immediately (asynchronously); no ack; the next req completes normally.
- if_addr changed while if_req is held after grant -> RAM sees the original address; back-to-back requests give IDLE for exactly one cycle between the two transactions.
